apb_cmd_master: RTL



---
 rtl/apb_cmd_master_pkg.sv | 23 ++
 rtl/apb_cmd_master_if.sv | 41 ++++
 rtl/apb_cmd_master_wait_timer.sv | 40 ++++
 rtl/apb_cmd_master.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master: FSM state encoding, default bus
// widths and the response record returned to the command source.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    localparam apb_rsp_t RSP_RESET = '{rdata: {APB_DATA_W{1'b0}}, err: 1'b0, timeout: 1'b0};

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command stream, response stream and APB bus of the command master.
// The master modport is the initiator's view; slave is the environment's view.
interface apb_cmd_master_if #(
    parameter int ADDR_W = apb_pkg::APB_ADDR_W,
    parameter int DATA_W = apb_pkg::APB_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel, penable, pwrite, pwdata
    );

endinterface

// File: rtl/apb_cmd_master_wait_timer.sv
// Saturating wait-state counter; expired flags the wait cycle that reaches
// TIMEOUT so the transfer can be aborted on that same cycle.
module apb_wait_timer #(
    parameter int              TO_W    = 8,
    parameter logic [TO_W-1:0] TIMEOUT = 8'd255
) (
    input  logic pclk,
    input  logic prst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] cnt_r;
    logic [TO_W-1:0] cnt_inc_s;

    // saturating increment, never wraps
    always_comb begin
        if (cnt_r == {TO_W{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + TO_W'(1);
        end
    end

    // wait counter register
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_inc_s;
        end
    end

    // the current wait cycle counts toward the limit; zero disables
    assign expired = (TIMEOUT != {TO_W{1'b0}}) && enable && (cnt_inc_s == TIMEOUT);

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns one valid/ready command into one APB transfer and
// returns one response; hung slaves are aborted by the wait timer.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int              ADDR_W  = APB_ADDR_W,
    parameter int              DATA_W  = APB_DATA_W,
    parameter int              TO_W    = 8,
    parameter logic [TO_W-1:0] TIMEOUT = 8'd255
) (
    input  logic                pclk,
    input  logic                prst_n,
    apb_cmd_master_if.master    bus,
    output logic                busy
);

    apb_mst_state_e    state_r, state_nx_s;
    logic              psel_r, psel_nx_s;
    logic              penable_r, penable_nx_s;
    logic              pwrite_r, pwrite_nx_s;
    logic [ADDR_W-1:0] paddr_r, paddr_nx_s;
    logic [DATA_W-1:0] pwdata_r, pwdata_nx_s;
    logic              rsp_valid_r, rsp_valid_nx_s;
    apb_rsp_t          rsp_r, rsp_nx_s;
    logic              busy_r;
    logic              cmd_ready_s;
    logic              tmr_clear_s;
    logic              tmr_en_s;
    logic              tmr_expired_s;

    assign tmr_en_s    = (state_r == ACCESS) && !bus.pready;
    assign tmr_clear_s = (state_r == RESP) && bus.rsp_ready;

    apb_wait_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk    (pclk),
        .prst_n  (prst_n),
        .clear   (tmr_clear_s),
        .enable  (tmr_en_s),
        .expired (tmr_expired_s)
    );

    // next-state and next-output logic; every registered output holds by default
    always_comb begin
        state_nx_s     = state_r;
        psel_nx_s      = psel_r;
        penable_nx_s   = penable_r;
        pwrite_nx_s    = pwrite_r;
        paddr_nx_s     = paddr_r;
        pwdata_nx_s    = pwdata_r;
        rsp_valid_nx_s = rsp_valid_r;
        rsp_nx_s       = rsp_r;
        cmd_ready_s    = 1'b0;
        case (state_r)
            IDLE: begin
                cmd_ready_s = 1'b1;
                if (bus.cmd_valid) begin
                    pwrite_nx_s  = bus.cmd_write;
                    paddr_nx_s   = bus.cmd_addr;
                    pwdata_nx_s  = bus.cmd_wdata;
                    psel_nx_s    = 1'b1;
                    penable_nx_s = 1'b0;
                    state_nx_s   = SETUP;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SETUP: begin
                penable_nx_s = 1'b1;
                state_nx_s   = ACCESS;
            end
            ACCESS: begin
                // pready takes priority over an expiring timer on the same cycle
                if (bus.pready) begin
                    rsp_nx_s.rdata   = pwrite_r ? {APB_DATA_W{1'b0}} : APB_DATA_W'(bus.prdata);
                    rsp_nx_s.err     = bus.pslverr;
                    rsp_nx_s.timeout = 1'b0;
                    psel_nx_s        = 1'b0;
                    penable_nx_s     = 1'b0;
                    rsp_valid_nx_s   = 1'b1;
                    state_nx_s       = RESP;
                end else if (tmr_expired_s) begin
                    rsp_nx_s.rdata   = {APB_DATA_W{1'b0}};
                    rsp_nx_s.err     = 1'b1;
                    rsp_nx_s.timeout = 1'b1;
                    psel_nx_s        = 1'b0;
                    penable_nx_s     = 1'b0;
                    rsp_valid_nx_s   = 1'b1;
                    state_nx_s       = RESP;
                end else begin
                    state_nx_s = ACCESS;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_nx_s = 1'b0;
                    state_nx_s     = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: begin
                psel_nx_s      = 1'b0;
                penable_nx_s   = 1'b0;
                rsp_valid_nx_s = 1'b0;
                state_nx_s     = IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_r     <= IDLE;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= {ADDR_W{1'b0}};
            pwdata_r    <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_r       <= RSP_RESET;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            psel_r      <= psel_nx_s;
            penable_r   <= penable_nx_s;
            pwrite_r    <= pwrite_nx_s;
            paddr_r     <= paddr_nx_s;
            pwdata_r    <= pwdata_nx_s;
            rsp_valid_r <= rsp_valid_nx_s;
            rsp_r       <= rsp_nx_s;
            busy_r      <= (state_nx_s != IDLE);
        end
    end

    assign bus.cmd_ready   = cmd_ready_s;
    assign bus.psel        = psel_r;
    assign bus.penable     = penable_r;
    assign bus.pwrite      = pwrite_r;
    assign bus.paddr       = paddr_r;
    assign bus.pwdata      = pwdata_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_r.rdata[DATA_W-1:0];
    assign bus.rsp_err     = rsp_r.err;
    assign bus.rsp_timeout = rsp_r.timeout;
    assign busy            = busy_r;

endmodule
